// File: rtl/ball_pkg.sv
// Shared types and constants for the multi-ball bouncer: FSM states, default
// widths and the reset-time layout of the balls.
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_POS_W = 9;
  localparam int DEF_VEL_W = 4;

  // Ball i starts at (INIT_H_BASE + INIT_H_STEP*i, INIT_V_BASE + INIT_V_STEP*i).
  localparam int INIT_H_BASE = 16;
  localparam int INIT_H_STEP = 32;
  localparam int INIT_V_BASE = 16;
  localparam int INIT_V_STEP = 24;
  localparam int INIT_VVEL   = 2;

endpackage

// File: rtl/ball_axis_step.sv
// Combinational single-axis motion step: advances pos by vel and reflects off
// the 0 and max walls, clamping the position onto the wall it hit.
module ball_axis_step #(
  parameter int POS_W = 9,
  parameter int VEL_W = 4
) (
  input  logic [POS_W-1:0]        pos,
  input  logic signed [VEL_W-1:0] vel,
  input  logic [POS_W-1:0]        max,
  output logic [POS_W-1:0]        next_pos,
  output logic signed [VEL_W-1:0] next_vel,
  output logic                    hit
);

  // One extra bit of headroom so pos+vel can never wrap.
  logic signed [POS_W:0] vel_ext;
  logic signed [POS_W:0] sum;
  logic signed [POS_W:0] mag;
  logic signed [POS_W:0] pos_ext;
  logic signed [POS_W:0] max_ext;

  always_comb begin
    vel_ext  = (POS_W+1)'(vel);
    pos_ext  = $signed({1'b0, pos});
    max_ext  = $signed({1'b0, max});
    sum      = pos_ext + vel_ext;
    mag      = -vel_ext;
    next_pos = sum[POS_W-1:0];
    next_vel = vel;
    hit      = 1'b0;
    if (vel > 0 && sum >= max_ext) begin
      next_pos = max;
      next_vel = -vel;
      hit      = 1'b1;
    end else if (vel < 0 && pos_ext <= mag) begin
      next_pos = '0;
      next_vel = -vel;
      hit      = 1'b1;
    end
  end

endmodule

// File: rtl/ball_multi_bouncer.sv
// Frame-rate animation of NUM_BALLS bouncing balls with a registered pixel colour
// output. Defining BALL_PAUSE_EN adds a pause input that freezes motion.
module ball_multi_bouncer
  import ball_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int POS_W     = ball_pkg::DEF_POS_W,
  parameter int VEL_W     = ball_pkg::DEF_VEL_W,
  parameter int BALL_SIZE = 4,
  parameter int H_ACTIVE  = 256,
  parameter int V_ACTIVE  = 240
) (
  input  logic             clk,
  input  logic             reset,
`ifdef BALL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             frame_tick,
  input  logic             display_on,
  input  logic [POS_W-1:0] hpos,
  input  logic [POS_W-1:0] vpos,
  output logic [2:0]       rgb,
  output logic             wall_hit,
  output logic             update_busy
);

  localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [POS_W-1:0] H_MAX = POS_W'(H_ACTIVE - BALL_SIZE);
  localparam logic [POS_W-1:0] V_MAX = POS_W'(V_ACTIVE - BALL_SIZE);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    hit_acc;
  logic [POS_W-1:0]        ball_h    [NUM_BALLS];
  logic [POS_W-1:0]        ball_v    [NUM_BALLS];
  logic signed [VEL_W-1:0] ball_hvel [NUM_BALLS];
  logic signed [VEL_W-1:0] ball_vvel [NUM_BALLS];

  logic [POS_W-1:0]        h_next, v_next;
  logic signed [VEL_W-1:0] hvel_next, vvel_next;
  logic                    h_hit, v_hit;
  logic                    start;

`ifdef BALL_PAUSE_EN
  assign start = frame_tick & ~pause;
`else
  assign start = frame_tick;
`endif

  ball_axis_step #(.POS_W(POS_W), .VEL_W(VEL_W)) u_h_step (
    .pos      (ball_h[idx]),
    .vel      (ball_hvel[idx]),
    .max      (H_MAX),
    .next_pos (h_next),
    .next_vel (hvel_next),
    .hit      (h_hit)
  );

  ball_axis_step #(.POS_W(POS_W), .VEL_W(VEL_W)) u_v_step (
    .pos      (ball_v[idx]),
    .vel      (ball_vvel[idx]),
    .max      (V_MAX),
    .next_pos (v_next),
    .next_vel (vvel_next),
    .hit      (v_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      hit_acc     <= 1'b0;
      wall_hit    <= 1'b0;
      update_busy <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        ball_h[i]    <= POS_W'(INIT_H_BASE + INIT_H_STEP * i);
        ball_v[i]    <= POS_W'(INIT_V_BASE + INIT_V_STEP * i);
        ball_hvel[i] <= (i % 2 == 0) ? VEL_W'(i + 1) : VEL_W'(-(i + 1));
        ball_vvel[i] <= (i % 2 == 0) ? VEL_W'(INIT_VVEL) : VEL_W'(-INIT_VVEL);
      end
    end else begin
      wall_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= UPDATE;
            idx         <= '0;
            hit_acc     <= 1'b0;
            update_busy <= 1'b1;
          end
        end
        UPDATE: begin
          ball_h[idx]    <= h_next;
          ball_hvel[idx] <= hvel_next;
          ball_v[idx]    <= v_next;
          ball_vvel[idx] <= vvel_next;
          // A corner hit sets both flags but still yields a single pulse.
          hit_acc        <= hit_acc | h_hit | v_hit;
          if (idx == IDX_W'(NUM_BALLS - 1)) begin
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          wall_hit    <= hit_acc;
          update_busy <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          update_busy <= 1'b0;
        end
      endcase
    end
  end

  // Reverse scan so the lowest-index ball is the last, winning assignment.
  logic [2:0]       pix;
  logic [POS_W-1:0] dh, dv;

  always_comb begin
    pix = 3'd0;
    dh  = '0;
    dv  = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      dh = hpos - ball_h[i];
      dv = vpos - ball_v[i];
      if (dh < POS_W'(BALL_SIZE) && dv < POS_W'(BALL_SIZE)) begin
        pix = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= 3'd0;
    end else begin
      rgb <= display_on ? pix : 3'd0;
    end
  end

endmodule

// File: tb/tb_ball_multi_bouncer.sv
// Bench for ball_multi_bouncer: pixel vector table, hand-written pass/reset
// sequences and a randomized frame run against a frame-level ball model.
module tb_ball_multi_bouncer;

  localparam int NB = 4;
  localparam int PW = 9;
  localparam int VW = 4;
  localparam int BS = 4;
  localparam int HA = 256;
  localparam int VA = 240;
  localparam int PMASK = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic          display_on;
  logic [PW-1:0] hpos;
  logic [PW-1:0] vpos;
  logic [2:0]    rgb;
  logic          wall_hit;
  logic          update_busy;
`ifdef BALL_PAUSE_EN
  logic          pause;
`endif

  always #5 clk = ~clk;

  ball_multi_bouncer #(
    .NUM_BALLS(NB), .POS_W(PW), .VEL_W(VW),
    .BALL_SIZE(BS), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef BALL_PAUSE_EN
    .pause       (pause),
`endif
    .frame_tick  (frame_tick),
    .display_on  (display_on),
    .hpos        (hpos),
    .vpos        (vpos),
    .rgb         (rgb),
    .wall_hit    (wall_hit),
    .update_busy (update_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Frame-level model of every ball.
  int mh [NB];
  int mv [NB];
  int mhv[NB];
  int mvv[NB];

  typedef struct {
    int hp;
    int vp;
    bit don;
    int exp;
  } pix_vec_t;

  pix_vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      mh[i]  = 16 + 32 * i;
      mv[i]  = 16 + 24 * i;
      mhv[i] = (i % 2 == 0) ? (i + 1) : -(i + 1);
      mvv[i] = (i % 2 == 0) ? 2 : -2;
    end
  endtask

  task automatic model_axis(inout int pos, inout int vel, input int max, output bit hit);
    hit = 1'b0;
    if (vel > 0 && pos + vel >= max) begin
      pos = max; vel = -vel; hit = 1'b1;
    end else if (vel < 0 && pos <= -vel) begin
      pos = 0; vel = -vel; hit = 1'b1;
    end else begin
      pos = pos + vel;
    end
  endtask

  task automatic model_frame(output bit any_hit);
    bit hh, vh;
    any_hit = 1'b0;
    for (int i = 0; i < NB; i++) begin
      model_axis(mh[i], mhv[i], HA - BS, hh);
      model_axis(mv[i], mvv[i], VA - BS, vh);
      any_hit = any_hit | hh | vh;
    end
  endtask

  function automatic int model_pix(input int hp, input int vp, input bit don);
    if (!don) return 0;
    for (int i = 0; i < NB; i++) begin
      if (((hp - mh[i]) & PMASK) < BS && ((vp - mv[i]) & PMASK) < BS) return i + 1;
    end
    return 0;
  endfunction

  task automatic check_balls(input string tag);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s_h%0d", tag, i), int'(dut.ball_h[i]), mh[i]);
      check($sformatf("%s_v%0d", tag, i), int'(dut.ball_v[i]), mv[i]);
      check($sformatf("%s_hvel%0d", tag, i), int'(dut.ball_hvel[i]), mhv[i]);
      check($sformatf("%s_vvel%0d", tag, i), int'(dut.ball_vvel[i]), mvv[i]);
    end
  endtask

  task automatic pixel(input int hp, input int vp, input bit don, input int exp);
    @(negedge clk);
    hpos       = PW'(hp);
    vpos       = PW'(vp);
    display_on = don;
    @(negedge clk);
    check($sformatf("rgb(%0d,%0d,%0d)", hp, vp, don), int'(rgb), exp);
  endtask

  // Pulse frame_tick, watch the pass for 12 cycles, optionally re-pulse at extra_k.
  task automatic tick_pass(input int extra_k, input bit expect_run);
    bit hit_exp;
    int busy_n;
    int hit_n;
    busy_n = 0;
    hit_n  = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      busy_n += int'(update_busy);
      hit_n  += int'(wall_hit);
      frame_tick = (k == extra_k);
    end
    frame_tick = 1'b0;
    hit_exp = 1'b0;
    if (expect_run) model_frame(hit_exp);
    check("busy_cycles", busy_n, expect_run ? NB + 1 : 0);
    check("wall_hit_pulses", hit_n, int'(hit_exp));
    check_balls("pass");
  endtask

  initial begin
    int hit_n;
    reset      = 1'b1;
    frame_tick = 1'b0;
    display_on = 1'b0;
    hpos       = '0;
    vpos       = '0;
`ifdef BALL_PAUSE_EN
    pause      = 1'b0;
`endif
    model_reset();

    vecs[0]  = '{17, 18, 1'b1, 1};
    vecs[1]  = '{20, 21, 1'b1, 1};
    vecs[2]  = '{18, 20, 1'b1, 1};
    vecs[3]  = '{21, 18, 1'b1, 0};
    vecs[4]  = '{17, 22, 1'b1, 0};
    vecs[5]  = '{16, 18, 1'b1, 0};
    vecs[6]  = '{17, 18, 1'b0, 0};
    vecs[7]  = '{46, 38, 1'b1, 2};
    vecs[8]  = '{49, 41, 1'b1, 2};
    vecs[9]  = '{50, 38, 1'b1, 0};
    vecs[10] = '{83, 66, 1'b1, 3};
    vecs[11] = '{108, 86, 1'b1, 4};
    vecs[12] = '{111, 89, 1'b1, 4};
    vecs[13] = '{0, 0, 1'b1, 0};

    repeat (2) @(negedge clk);
    check("reset_rgb", int'(rgb), 0);
    check("reset_wall_hit", int'(wall_hit), 0);
    check("reset_busy", int'(update_busy), 0);
    check_balls("reset");
    reset = 1'b0;

    // First pass from the reset layout.
    tick_pass(0, 1'b1);
    check("ball0_h_first", int'(dut.ball_h[0]), 17);
    check("ball0_v_first", int'(dut.ball_v[0]), 18);
    check("ball1_h_first", int'(dut.ball_h[1]), 46);
    check("ball1_v_first", int'(dut.ball_v[1]), 38);

    for (int i = 0; i < 14; i++) begin
      pixel(vecs[i].hp, vecs[i].vp, vecs[i].don, vecs[i].exp);
    end

    // A second tick inside the pass must not cause a second step.
    tick_pass(2, 1'b1);

    // Reset in the middle of a pass restores the layout and drops wall_hit.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("midreset_busy", int'(update_busy), 0);
    check_balls("midreset");
    @(negedge clk);
    reset = 1'b0;
    hit_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      hit_n += int'(wall_hit);
    end
    check("midreset_wall_hit", hit_n, 0);

    // Randomized frames across many wall bounces.
    for (int f = 0; f < 300; f++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        int j, hp, vp;
        bit don;
        j   = $urandom_range(0, NB - 1);
        hp  = (mh[j] + $urandom_range(0, 6) - 1) & PMASK;
        vp  = (mv[j] + $urandom_range(0, 6) - 1) & PMASK;
        don = ($urandom_range(0, 7) != 0);
        pixel(hp, vp, don, model_pix(hp, vp, don));
      end
      tick_pass(($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, 1'b1);
    end

`ifdef BALL_PAUSE_EN
    pause = 1'b1;
    for (int t = 0; t < 3; t++) tick_pass(0, 1'b0);
    pixel(mh[0], mv[0], 1'b1, model_pix(mh[0], mv[0], 1'b1));
    pause = 1'b0;
    tick_pass(0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_multi_bouncer.md
Name: ball_multi_bouncer

Overview:
- Frame-rate animation engine for NUM_BALLS independent square balls, each bouncing off all four edges of the active area.
- Runs fully synchronous on the pixel clock. A one-cycle frame_tick strobe from the sync generator advances motion; the block never clocks on vsync.
- Sits between the hvsync generator and the top-level rgb output. Produces per-pixel ball colour and wall-hit events for sound/score logic.

Parameters:
- NUM_BALLS, 4, number of balls (1..7).
- POS_W, 9, width of hpos/vpos and ball position registers.
- VEL_W, 4, signed velocity width (two's complement).
- BALL_SIZE, 4, ball edge length in pixels.
- H_ACTIVE, 256, visible width in pixels.
- V_ACTIVE, 240, visible height in pixels.

Ports:
- clk  in  1  pixel clock
- reset  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse, once per frame, at start of vertical blank
- display_on  in  1  visible-area flag from sync generator
- hpos  in  POS_W  current pixel column
- vpos  in  POS_W  current pixel row
- rgb  out  3  {b,g,r} pixel colour, registered
- wall_hit  out  1  one-cycle pulse: a ball hit any edge during the current update pass
- update_busy  out  1  high while the update pass runs

Behaviour:
- Reset (async) values:
  - rgb=0, wall_hit=0, update_busy=0, state=IDLE, idx=0.
  - Ball i: h=16+32*i, v=16+24*i.
  - hvel=+(i+1) for even i, -(i+1) for odd i.
  - vvel=+2 for even i, -2 for odd i.
  - Legal parameter sets satisfy 16+32*(NUM_BALLS-1) <= H_ACTIVE-BALL_SIZE and 16+24*(NUM_BALLS-1) <= V_ACTIVE-BALL_SIZE.
- FSM states are IDLE, UPDATE and DONE:
  - IDLE -> UPDATE on frame_tick; idx<=0.
  - UPDATE: one ball per cycle. Ball idx is stepped on both axes, then idx++. The cycle with idx==NUM_BALLS-1 -> DONE.
  - DONE: one cycle; wall_hit<=OR of the hit flags accumulated this pass; -> IDLE.
  - update_busy=1 in UPDATE and DONE. A full pass takes NUM_BALLS+1 cycles after frame_tick.
- frame_tick during UPDATE or DONE is ignored; no queuing.
- Axis step, per axis, with MAX = ACTIVE-BALL_SIZE:
  - vel>0 and pos+vel >= MAX: pos<=MAX, vel<=-vel, hit.
  - vel<0 and pos <= |vel|: pos<=0, vel<=-vel, hit.
  - Otherwise pos<=pos+vel.
  - vel==0: no motion, no hit.
  - The sum uses POS_W+1 bits, so no wrap-around is possible.
  - The hit flag accumulates across the pass and is cleared entering UPDATE.
- Both axes hit on the same cycle (corner): both velocities negate; a single hit is counted.
- Render:
  - Ball i covers the pixel when (hpos-h_i) < BALL_SIZE and (vpos-v_i) < BALL_SIZE, using unsigned POS_W-bit differences.
  - Colour of ball i = i+1 (3-bit).
  - Overlapping balls: lowest index wins.
  - No ball or display_on=0 gives 0.
  - rgb is registered: 1-cycle latency from hpos/vpos/display_on.
- Render uses live positions; any update during a visible line is acceptable.
- Reset asserted mid-pass: immediate return to reset state; wall_hit is not emitted.

Optional Feature:
- BALL_PAUSE_EN defined:
  - Adds input port pause (1 bit).
  - While pause=1, frame_tick is ignored in IDLE and positions freeze. Rendering continues.
  - A pass already in progress completes.
- BALL_PAUSE_EN undefined: no pause port; every frame_tick in IDLE starts a pass.

Decomposition:
- Package ball_pkg holds:
  - state enum (IDLE/UPDATE/DONE).
  - default widths (POS_W, VEL_W).
  - initial-position constants (16, 32, 16, 24) and initial vvel magnitude 2.
- Sub-module ball_axis_step: combinational single-axis step.
  - Parameters POS_W, VEL_W.
  - Inputs pos, vel, max. Outputs next_pos, next_vel, hit.
  - Instantiated twice, for the h and v axes, on the idx-selected ball.

Test Plan:
- Reset release, one frame_tick -> after 5 cycles ball0=(17,18), ball1=(46,38) [h 48-2, v 40-2]; wall_hit=0; update_busy high exactly 5 cycles.
- Force ball0 h=251, hvel=+1, tick -> h=252, hvel=-1, wall_hit pulses once in DONE.
- Ball1 v=1, vvel=-2, tick -> v=0, vvel=+2, wall_hit=1. Corner case h=252/v=236 with both vel>0 -> both negate, one wall_hit pulse.
- Pixel scan with ball0 at (17,18), display_on=1: hpos=17..20, vpos=18..21 -> rgb=3'b001 one cycle later. hpos=21 -> 0. display_on=0 -> 0. Overlap ball0/ball1 -> colour 1.
- frame_tick re-pulsed at cycle 2 of a pass -> ignored, positions advance once. Reset at cycle 3 -> all balls at initial values, no wall_hit.
- BALL_PAUSE_EN: pause=1 over 3 ticks -> positions unchanged, rgb still draws. Release then one tick -> one step.
